// File: rtl/icache_axi_refill_pkg.sv
// icache_axi_refill_pkg: shared I-cache refill geometry, AXI encodings and FSM states
package icache_axi_refill_pkg;
  localparam int LINE_WORDS = 8;
  localparam int OFFSET_W = 5;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;
endpackage

// File: rtl/refill_line_buf.sv
// refill_line_buf: cache line buffer, one word written per beat, whole line read out
//   clk, rst       clock, async active-high reset (clears the line)
//   i_we, i_idx    write strobe and word index
//   i_wdata        word to write
//   o_line         full line, word k in bits [32k+31:32k]
module refill_line_buf #(
  parameter int LINE_WORDS = 8,
  parameter int IDX_W = $clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic [31:0]              i_wdata,
  output logic [LINE_WORDS*32-1:0] o_line
);
  logic [LINE_WORDS-1:0][31:0] r_words;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_words <= '0;
    else if (i_we) r_words[i_idx] <= i_wdata;
  assign o_line = r_words;
endmodule

// File: rtl/icache_axi_refill.sv
// icache_axi_refill: AXI4 read master fetching one I-cache line per INCR burst
//   icache_rreq_i/icache_raddr_i  refill request (level) and miss address
//   rend_o, cacheline_rdata_o     line-complete pulse and assembled line
//   refill_err_o                  sticky protocol/response error flag
//   ar*/r*                        AXI4 read address and read data channels
module icache_axi_refill
  import icache_axi_refill_pkg::*;
#(
  parameter int LINE_WORDS = icache_axi_refill_pkg::LINE_WORDS,
  parameter int OFFSET_W = icache_axi_refill_pkg::OFFSET_W,
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     icache_rreq_i,
  input  logic [31:0]              icache_raddr_i,
  output logic                     rend_o,
  output logic [LINE_WORDS*32-1:0] cacheline_rdata_o,
  output logic                     refill_err_o,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);
  localparam int CNT_W = $clog2(LINE_WORDS);
  state_t r_state;
  logic [31:0] r_araddr;
  logic [CNT_W-1:0] r_cnt;
  logic r_arvalid, r_rready, r_rend, r_err;
  logic w_beat, w_bad, w_unused;
  assign w_beat = r_rready && rvalid;
  // rlast must coincide exactly with the final word slot; either mismatch is an error
  assign w_bad = rresp != RESP_OKAY || rid != AXI_ID || (rlast != (r_cnt == CNT_W'(LINE_WORDS - 1)));
  assign w_unused = ^icache_raddr_i[OFFSET_W-1:0];
  assign arid = AXI_ID;
  assign araddr = r_araddr;
  assign arlen = 8'(LINE_WORDS - 1);
  assign arsize = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign arvalid = r_arvalid;
  assign rready = r_rready;
  assign rend_o = r_rend;
  assign refill_err_o = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_araddr <= '0;
      r_cnt <= '0;
      r_arvalid <= 1'b0;
      r_rready <= 1'b0;
      r_rend <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_rend <= 1'b0;
      case (r_state)
        S_IDLE: if (icache_rreq_i) begin
          r_araddr <= {icache_raddr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
          r_cnt <= '0;
          r_arvalid <= 1'b1;
          r_state <= S_AR;
        end
        S_AR: if (arready) begin
          r_arvalid <= 1'b0;
          r_rready <= 1'b1;
          r_state <= S_R;
        end
        S_R: if (w_beat) begin
          r_cnt <= r_cnt + 1'b1;
          r_err <= r_err | w_bad;
          if (rlast) begin
            r_rready <= 1'b0;
            r_rend <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  refill_line_buf #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk(clk),
    .rst(rst),
    .i_we(w_beat),
    .i_idx(r_cnt),
    .i_wdata(rdata),
    .o_line(cacheline_rdata_o)
  );
endmodule

// File: tb/tb_icache_axi_refill.sv
// tb_icache_axi_refill: table-driven and randomized refills checked against a line/flag model
module tb_icache_axi_refill;
  localparam int LW = 8;
  logic clk = 0, rst = 1;
  logic icache_rreq_i = 0, arready = 0, rlast = 0, rvalid = 0;
  logic [31:0] icache_raddr_i = 0, rdata = 0;
  logic [3:0] rid = 0;
  logic [1:0] rresp = 0;
  logic rend_o, refill_err_o, arvalid, rready;
  logic [LW*32-1:0] cacheline_rdata_o;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  int n_chk = 0, n_err = 0;
  logic [31:0] m_words [LW];
  bit m_err;
  icache_axi_refill dut (
    .clk(clk), .rst(rst), .icache_rreq_i(icache_rreq_i), .icache_raddr_i(icache_raddr_i),
    .rend_o(rend_o), .cacheline_rdata_o(cacheline_rdata_o), .refill_err_o(refill_err_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit pre_rst;
    logic [31:0] addr;
    int ar_wait;
    int gap;
    int bad_beat;
    logic [1:0] bad_resp;
    logic [3:0] bad_rid;
    int nbeats;
    bit hold;
    logic [31:0] base;
    logic [31:0] exp_a;
    bit exp_err;
  } vec_t;
  vec_t tv [10];
  task automatic chk(input string nm, input logic [LW*32-1:0] act, input logic [LW*32-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [LW*32-1:0] model_line();
    logic [LW*32-1:0] p;
    for (int k = 0; k < LW; k++) p[32*k +: 32] = m_words[k];
    return p;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    m_err = 0;
    for (int k = 0; k < LW; k++) m_words[k] = 0;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rend", rend_o, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_err", refill_err_o, 0);
    chk("rst_line", cacheline_rdata_o, 0);
    @(negedge clk) rst = 0;
    tick();
  endtask
  task automatic refill(input logic [31:0] addr, input int ar_wait, input int gap, input int bad_beat,
                        input logic [1:0] bad_resp, input logic [3:0] bad_rid, input int nbeats,
                        input bit hold, input logic [31:0] base, input bit rnd, input logic [31:0] exp_a);
    int ng;
    icache_rreq_i = 1;
    icache_raddr_i = addr;
    tick();
    chk("ar_valid", arvalid, 1);
    chk("araddr", araddr, exp_a);
    chk("arlen", arlen, LW - 1);
    chk("arsize", arsize, 2);
    chk("arburst", arburst, 1);
    chk("arid", arid, 0);
    chk("ar_rready", rready, 0);
    for (int w = 0; w < ar_wait; w++) begin
      icache_raddr_i = $urandom;
      rvalid = 1;
      rlast = 1;
      rdata = $urandom;
      tick();
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, exp_a);
      chk("ar_hold_rready", rready, 0);
    end
    rvalid = 0;
    rlast = 0;
    arready = 1;
    tick();
    arready = 0;
    chk("r_arvalid", arvalid, 0);
    chk("r_rready", rready, 1);
    for (int b = 0; b < nbeats; b++) begin
      ng = gap == 1 ? (b > 0 ? 1 : 0) : gap == 2 ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < ng; g++) begin
        tick();
        chk("gap_rend", rend_o, 0);
      end
      rvalid = 1;
      rdata = rnd ? $urandom : base + b;
      rid = b == bad_beat ? bad_rid : 4'h0;
      rresp = b == bad_beat ? bad_resp : 2'b00;
      rlast = b == nbeats - 1;
      m_words[b % LW] = rdata;
      if (rresp != 0 || rid != 0 || (rlast != (b == LW - 1))) m_err = 1;
      tick();
      chk("beat_rend", rend_o, b == nbeats - 1);
      rvalid = 0;
      rlast = 0;
      rid = 0;
      rresp = 0;
    end
    chk("done_line", cacheline_rdata_o, model_line());
    chk("done_err", refill_err_o, m_err);
    chk("done_rready", rready, 0);
    if (hold) icache_raddr_i = addr + 32'h40;
    else icache_rreq_i = 0;
    tick();
    chk("post_rend", rend_o, 0);
    chk("post_no_ar", arvalid, 0);
    chk("post_line", cacheline_rdata_o, model_line());
  endtask
  initial begin
    bit prev_hold;
    logic [31:0] a;
    int nb;
    tv[0] = '{0, 32'h1FC0_0014, 0, 0, -1, 2'b00, 4'h0, 8, 0, 32'h0000_00A0, 32'h1FC0_0000, 0};
    tv[1] = '{0, 32'h0000_1234, 5, 0, -1, 2'b00, 4'h0, 8, 0, 32'h0000_0100, 32'h0000_1220, 0};
    tv[2] = '{0, 32'h8000_003C, 2, 1, -1, 2'b00, 4'h0, 8, 0, 32'h0000_2000, 32'h8000_0020, 0};
    tv[3] = '{0, 32'h1234_5678, 0, 0, 3, 2'b10, 4'h0, 8, 0, 32'h0000_0300, 32'h1234_5660, 1};
    tv[4] = '{0, 32'hABCD_EF00, 1, 2, -1, 2'b00, 4'h0, 8, 1, 32'h0000_0400, 32'hABCD_EF00, 1};
    tv[5] = '{0, 32'hABCD_EF40, 0, 0, -1, 2'b00, 4'h0, 8, 0, 32'h0000_0500, 32'hABCD_EF40, 1};
    tv[6] = '{1, 32'h0000_0040, 0, 0, 5, 2'b00, 4'h3, 8, 0, 32'h0000_0600, 32'h0000_0040, 1};
    tv[7] = '{1, 32'h0000_00C4, 0, 0, -1, 2'b00, 4'h0, 10, 0, 32'h0000_0700, 32'h0000_00C0, 1};
    tv[8] = '{1, 32'h0000_0100, 0, 0, -1, 2'b00, 4'h0, 8, 0, 32'h0000_0800, 32'h0000_0100, 0};
    tv[9] = '{0, 32'h0000_0160, 0, 0, -1, 2'b00, 4'h0, 5, 0, 32'h0000_0900, 32'h0000_0160, 1};
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (tv[i].pre_rst) do_reset();
      refill(tv[i].addr, tv[i].ar_wait, tv[i].gap, tv[i].bad_beat, tv[i].bad_resp, tv[i].bad_rid,
             tv[i].nbeats, tv[i].hold, tv[i].base, 0, tv[i].exp_a);
      chk("tbl_err", refill_err_o, tv[i].exp_err);
    end
    do_reset();
    icache_rreq_i = 1;
    icache_raddr_i = 32'h0000_0300;
    tick();
    arready = 1;
    tick();
    arready = 0;
    for (int b = 0; b < 5; b++) begin
      rvalid = 1;
      rdata = 32'hDEAD_0000 + b;
      rlast = 0;
      tick();
    end
    rvalid = 0;
    icache_rreq_i = 0;
    do_reset();
    refill(32'h0000_0200, 1, 0, -1, 2'b00, 4'h0, 8, 0, 32'h0000_0C00, 0, 32'h0000_0200);
    chk("after_rst_err", refill_err_o, 0);
    prev_hold = 0;
    a = 0;
    for (int i = 0; i < 25; i++) begin
      bit h;
      if (!prev_hold) begin
        if ($urandom_range(0, 3) == 0) do_reset();
        a = $urandom;
      end
      h = $urandom_range(0, 1);
      nb = $urandom_range(0, 3) == 0 ? $urandom_range(1, 12) : LW;
      refill(a, $urandom_range(0, 3), 2, $urandom_range(0, 15), 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) ? 4'h0 : 4'h5, nb, h, 0, 1, a & ~32'(LW * 4 - 1));
      prev_hold = h;
      a = a + 32'h40;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
